// File: rtl/pi_pkg.sv
// rtl/pi_pkg.sv - shared types and constants for the spigot pi datapath
package pi_pkg;

  // Emitter FSM: nothing held, predigit held, emitting predigit, emitting nines.
  typedef enum logic [1:0] {
    S_EMPTY,
    S_HOLD,
    S_PRE,
    S_NINES
  } emit_state_t;

  localparam int L_DIGIT_W = 4;

  // Predigit value that signals a carry into the held digits.
  localparam logic [L_DIGIT_W-1:0] L_CARRY_Q = 4'd10;

endpackage

// File: rtl/spigot_digit_emitter.sv
// rtl/spigot_digit_emitter.sv - resolves predigits, nine-runs and carries into final pi digits
//
// Purpose: holds the latest predigit plus a run of 9s behind it, applies a
// carry (predigit 10) to the held run, and streams final decimal digits out.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   q_valid/q_ready predigit stream from the divider (q_in 0..10 legal)
//   flush           end of computation: emit everything still held
//   digit_valid/digit_ready/digit_out/digit_last  final digit stream
//   nine_cnt        current held-nines count
//   err             sticky: illegal predigit, carry into 9, or count overflow
module spigot_digit_emitter
  import pi_pkg::*;
#(
  parameter int P_CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [3:0]             q_in,
  input  logic                   flush,
  output logic                   digit_valid,
  input  logic                   digit_ready,
  output logic [3:0]             digit_out,
  output logic                   digit_last,
  output logic [P_CNT_WIDTH-1:0] nine_cnt,
  output logic                   err
);

  localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

  emit_state_t            state;
  logic [3:0]             pre;
  logic [P_CNT_WIDTH-1:0] cnt;
  logic [3:0]             out_pre;
  logic [3:0]             fill;
  logic                   last_f;

  logic q_fire;
  logic d_fire;

  assign q_fire   = q_valid && q_ready;
  assign d_fire   = digit_valid && digit_ready;
  assign nine_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      pre         <= '0;
      cnt         <= '0;
      out_pre     <= '0;
      fill        <= '0;
      last_f      <= 1'b0;
      q_ready     <= 1'b0;
      digit_valid <= 1'b0;
      digit_out   <= '0;
      digit_last  <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          // Also brings q_ready up in the first cycle after reset.
          q_ready <= 1'b1;
          if (q_fire) begin
            if (q_in <= 4'd9) begin
              pre   <= q_in;
              cnt   <= '0;
              state <= S_HOLD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (q_fire) begin
            if (q_in == 4'd9) begin
              // Another nine joins the run; saturate rather than wrap.
              if (cnt == CNT_MAX) err <= 1'b1;
              else                cnt <= cnt + CNT_ONE;
            end else if (q_in < 4'd9) begin
              // No carry can reach the held digits any more: release them.
              out_pre     <= pre;
              fill        <= 4'd9;
              pre         <= q_in;
              state       <= S_PRE;
              q_ready     <= 1'b0;
              digit_valid <= 1'b1;
              digit_out   <= pre;
              digit_last  <= 1'b0;
            end else if (q_in == L_CARRY_Q) begin
              // Carry ripples through the nines (they become 0s) into pre.
              out_pre     <= (pre == 4'd9) ? 4'd0 : pre + 4'd1;
              fill        <= 4'd0;
              pre         <= 4'd0;
              state       <= S_PRE;
              q_ready     <= 1'b0;
              digit_valid <= 1'b1;
              digit_out   <= (pre == 4'd9) ? 4'd0 : pre + 4'd1;
              digit_last  <= 1'b0;
              if (pre == 4'd9) err <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (flush) begin
            out_pre     <= pre;
            fill        <= 4'd9;
            last_f      <= 1'b1;
            state       <= S_PRE;
            q_ready     <= 1'b0;
            digit_valid <= 1'b1;
            digit_out   <= pre;
            digit_last  <= (cnt == '0);
          end
        end

        S_PRE: begin
          if (d_fire) begin
            if (cnt != '0) begin
              state      <= S_NINES;
              digit_out  <= fill;
              digit_last <= last_f && (cnt == CNT_ONE);
            end else begin
              state       <= last_f ? S_EMPTY : S_HOLD;
              last_f      <= 1'b0;
              q_ready     <= 1'b1;
              digit_valid <= 1'b0;
              digit_last  <= 1'b0;
            end
          end
        end

        S_NINES: begin
          if (d_fire) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state       <= last_f ? S_EMPTY : S_HOLD;
              last_f      <= 1'b0;
              q_ready     <= 1'b1;
              digit_valid <= 1'b0;
              digit_last  <= 1'b0;
            end else begin
              // Next digit is the final one when exactly two remain now.
              digit_last <= last_f && (cnt == (CNT_ONE + CNT_ONE));
            end
          end
        end

        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule
